// File: rtl/branch_pdt.sv
// Tournament branch predictor (gshare + bimodal + chooser) with speculative GHR and mispredict repair.
// Optional feature macro: BPD_CHOOSER_EN (bimodal table and chooser); undefined builds a gshare-only predictor.
module branch_pdt #(
  parameter int IDX_W  = 10,
  parameter int HIST_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic [31:0]       if_pc,
  input  logic              if_is_branch,
  output logic              pdt_res_o,
  output logic              which_pdt_o,
  output logic [HIST_W-1:0] history_o,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic              upd_pdt_res,
  input  logic [HIST_W-1:0] upd_history
);

  localparam int N = 1 << IDX_W;

  logic [HIST_W-1:0] ghr_reg, ghr_next;
  logic [1:0]        gpht_reg [N];
  logic [IDX_W-1:0]  if_bidx, if_gidx, upd_bidx, upd_gidx;
  logic [1:0]        gctr;
  logic              mispredict;
  logic              unused_bits;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic inc);
    if (inc) return (c == 2'd3) ? c : c + 2'd1;
    else     return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  assign if_bidx    = if_pc[IDX_W+1:2];
  assign if_gidx    = ghr_reg ^ if_bidx;
  assign upd_bidx   = upd_pc[IDX_W+1:2];
  assign upd_gidx   = upd_history ^ upd_bidx;
  assign gctr       = gpht_reg[if_gidx];
  assign history_o  = ghr_reg;
  assign mispredict = upd_valid && (upd_pdt_res != upd_taken);

  assign unused_bits = ^{stall[5:2], stall[0], if_pc[31:IDX_W+2], if_pc[1:0],
                         upd_pc[31:IDX_W+2], upd_pc[1:0]};

  // Repair from the resolved branch wins over the speculative shift of the branch in IF.
  always_comb begin
    ghr_next = ghr_reg;
    if (if_is_branch && !stall[1])
      ghr_next = {ghr_reg[HIST_W-2:0], pdt_res_o};
    if (mispredict)
      ghr_next = {upd_history[HIST_W-2:0], upd_taken};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ghr_reg <= '0;
    else      ghr_reg <= ghr_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) gpht_reg[i] <= 2'b01;
    end else if (upd_valid) begin
      gpht_reg[upd_gidx] <= sat_step(gpht_reg[upd_gidx], upd_taken);
    end
  end

`ifdef BPD_CHOOSER_EN
  logic [1:0] bpht_reg    [N];
  logic [1:0] chooser_reg [N];
  logic [1:0] bctr;
  logic       sel, g_ok, b_ok;

  assign bctr = bpht_reg[if_bidx];
  assign sel  = chooser_reg[if_bidx][1];

  always_comb begin
    pdt_res_o   = 1'b0;
    which_pdt_o = 1'b0;
    if (if_is_branch) begin
      which_pdt_o = sel;
      pdt_res_o   = sel ? gctr[1] : bctr[1];
    end
  end

  // Chooser learns only from pre-update counter contents, and only when the two disagree in accuracy.
  assign g_ok = (gpht_reg[upd_gidx][1] == upd_taken);
  assign b_ok = (bpht_reg[upd_bidx][1] == upd_taken);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        bpht_reg[i]    <= 2'b01;
        chooser_reg[i] <= 2'b10;
      end
    end else if (upd_valid) begin
      bpht_reg[upd_bidx] <= sat_step(bpht_reg[upd_bidx], upd_taken);
      if (g_ok != b_ok)
        chooser_reg[upd_bidx] <= sat_step(chooser_reg[upd_bidx], g_ok);
    end
  end
`else
  always_comb begin
    pdt_res_o   = if_is_branch & gctr[1];
    which_pdt_o = if_is_branch;
  end
`endif

endmodule
